// File: rtl/bsg_credit_to_ready_fifo_if.sv
// Purpose: bundles the credit-protected input stream, the valid/yumi consumer side and the status outputs.
// Latency: none (signal bundle only).
// Backpressure: none on the input stream (credit protected); consumer side uses valid/yumi.
// Ports: v_i/data_i incoming words, v_o/data_o head word, yumi_i consumer take,
//        credit_o credit pulse to upstream, overflow_o sticky error.
interface bsg_credit_to_ready_fifo_if #(
    parameter int width_p = 8
);
    logic               v_i;
    logic [width_p-1:0] data_i;
    logic               v_o;
    logic [width_p-1:0] data_o;
    logic               yumi_i;
    logic               credit_o;
    logic               overflow_o;

    // master: upstream sender plus local consumer (testbench side)
    modport master (
        output v_i, data_i, yumi_i,
        input  v_o, data_o, credit_o, overflow_o
    );

    // slave: the FIFO itself
    modport slave (
        input  v_i, data_i, yumi_i,
        output v_o, data_o, credit_o, overflow_o
    );
endinterface

// File: rtl/bsg_credit_to_ready_fifo.sv
// Purpose: buffers a credit-protected valid-only stream in an els_p-entry FIFO and returns one credit per word consumed.
// Latency: 1 cycle v_i -> v_o; credit_o pulses 1 cycle after a dequeue (plus els_p initial credits after reset).
// Backpressure: none on input (credits bound occupancy); a word arriving while full and not dequeuing is dropped and flags overflow_o.
// Ports: clk_i clock; reset_n_i synchronous active-low reset; bus (slave) carries
//        v_i/data_i in, v_o/data_o/yumi_i consumer handshake, credit_o and overflow_o out.
module bsg_credit_to_ready_fifo #(
    parameter int width_p = 8,
    parameter int els_p   = 10
) (
    input logic                     clk_i,
    input logic                     reset_n_i,
    bsg_credit_to_ready_fifo_if.slave bus
);

    localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w = $clog2(els_p + 1);

    localparam logic [ptr_w-1:0] last_ptr = ptr_w'(els_p - 1);
    localparam logic [cnt_w-1:0] full_cnt = cnt_w'(els_p);
    localparam logic [cnt_w-1:0] one_cnt  = cnt_w'(1);
    localparam logic [ptr_w-1:0] zero_ptr = '0;
    localparam logic [ptr_w-1:0] one_ptr  = ptr_w'(1);

    logic [width_p-1:0] mem [els_p];
    logic [ptr_w-1:0]   rd_ptr;
    logic [ptr_w-1:0]   wr_ptr;
    logic [cnt_w-1:0]   count;
    logic [cnt_w-1:0]   pend_r;
    logic               credit_r;
    logic               overflow_r;

    logic               full;
    logic               not_empty;
    logic               deq;
    logic               enq;
    logic               drop;
    logic               credit_next;
    logic [cnt_w-1:0]   pend_next;

    assign full      = (count == full_cnt);
    assign not_empty = (count != '0);
    assign deq       = bus.yumi_i & not_empty;
    // When full, a same-cycle dequeue frees the slot that wr_ptr points at.
    assign enq       = bus.v_i & (~full | deq);
    assign drop      = bus.v_i & full & ~deq;

    // credit_next = (pend + deq) != 0 and pend_next = pend + deq - credit_next,
    // rewritten so the sum never needs an extra bit: with pend==0 the dequeue's
    // credit goes straight out; otherwise one owed credit goes out and a
    // dequeue simply replaces it.
    assign credit_next = (pend_r != '0) | deq;
    assign pend_next   = ((pend_r != '0) && !deq) ? (pend_r - one_cnt) : pend_r;

    function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
        return (p == last_ptr) ? zero_ptr : (p + one_ptr);
    endfunction

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            pend_r     <= full_cnt;
            credit_r   <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            if (enq) wr_ptr <= ptr_inc(wr_ptr);
            if (deq) rd_ptr <= ptr_inc(rd_ptr);
            if (enq && !deq)      count <= count + one_cnt;
            else if (deq && !enq) count <= count - one_cnt;
            pend_r   <= pend_next;
            credit_r <= credit_next;
            if (drop) overflow_r <= 1'b1;
        end
    end

    // Storage needs no reset; pointers and count define validity.
    always_ff @(posedge clk_i) begin
        if (reset_n_i && enq) mem[wr_ptr] <= bus.data_i;
    end

    assign bus.v_o        = not_empty;
    assign bus.data_o     = mem[rd_ptr];
    assign bus.credit_o   = credit_r;
    assign bus.overflow_o = overflow_r;

endmodule

// File: tb/tb_bsg_credit_to_ready_fifo.sv
module tb_bsg_credit_to_ready_fifo;
    localparam int ELS = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bsg_credit_to_ready_fifo_if #(.width_p(8)) bus ();

    bsg_credit_to_ready_fifo #(.width_p(8), .els_p(ELS)) dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .bus       (bus)
    );

    int checks = 0;
    int failures = 0;

    // reference model: word queue, owed-credit count, expected credit/overflow
    logic [7:0] q[$];
    int         m_pend = ELS;
    logic       m_credit = 1'b0;
    logic       m_ovf = 1'b0;
    int         up_cred = 0;
    int         seen_credits = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle: check outputs of current state, update model, advance.
    task automatic tick(input logic v, input logic [7:0] d, input logic y);
        logic deq;
        bus.v_i    = v;
        bus.data_i = d;
        bus.yumi_i = y && (q.size() != 0);
        chk("v_o", 32'(bus.v_o), 32'(q.size() != 0));
        if (q.size() != 0) chk("data_o", 32'(bus.data_o), 32'(q[0]));
        chk("credit_o", 32'(bus.credit_o), 32'(m_credit));
        chk("overflow_o", 32'(bus.overflow_o), 32'(m_ovf));
        if (bus.credit_o) seen_credits++;
        if (m_credit) up_cred++;
        if (v) up_cred--;
        deq = y && (q.size() != 0);
        if (deq) q.delete(0);
        if (v) begin
            if (q.size() < ELS) q.push_back(d);
            else m_ovf = 1'b1;
        end
        m_credit = (m_pend + int'(deq)) != 0;
        m_pend   = m_pend + int'(deq) - int'(m_credit);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_cycle();
        rst_n = 1'b0;
        bus.v_i = 1'b0;
        bus.data_i = 8'h00;
        bus.yumi_i = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
        m_pend = ELS;
        m_credit = 1'b0;
        m_ovf = 1'b0;
        up_cred = 0;
    endtask

    initial begin
        logic v;
        logic [7:0] d;
        bus.v_i = 1'b0;
        bus.data_i = 8'h00;
        bus.yumi_i = 1'b0;
        #1;

        // reset and reset-state checks
        reset_cycle();
        reset_cycle();
        chk("rst_v_o", 32'(bus.v_o), 32'd0);
        chk("rst_credit_o", 32'(bus.credit_o), 32'd0);
        chk("rst_overflow_o", 32'(bus.overflow_o), 32'd0);

        // initial credit burst: exactly ELS pulses
        seen_credits = 0;
        for (int i = 0; i < ELS + 3; i++) tick(1'b0, 8'h00, 1'b0);
        chk("burst_count", 32'(seen_credits), 32'(ELS));

        // single word with yumi tied to v_o
        tick(1'b1, 8'hA5, 1'b0);
        chk("a5_v_o", 32'(bus.v_o), 32'd1);
        chk("a5_data_o", 32'(bus.data_o), 32'hA5);
        chk("a5_no_early_credit", 32'(bus.credit_o), 32'd0);
        tick(1'b0, 8'h00, 1'b1);
        chk("a5_credit_t2", 32'(bus.credit_o), 32'd1);
        tick(1'b0, 8'h00, 1'b1);
        chk("a5_credit_t3", 32'(bus.credit_o), 32'd0);

        // fill then drain in order
        for (int i = 0; i < ELS; i++) tick(1'b1, 8'(i), 1'b0);
        chk("fill_data_o", 32'(bus.data_o), 32'h00);
        for (int i = 0; i < ELS + 2; i++) tick(1'b0, 8'h00, 1'b1);
        chk("drain_empty", 32'(bus.v_o), 32'd0);

        // full + simultaneous enqueue/dequeue
        for (int i = 0; i < ELS; i++) tick(1'b1, 8'(8'h10 + i), 1'b0);
        tick(1'b1, 8'hEE, 1'b1);
        chk("full_deq_ovf", 32'(bus.overflow_o), 32'd0);
        chk("full_deq_head", 32'(bus.data_o), 32'h11);

        // full without dequeue -> drop, sticky overflow
        tick(1'b1, 8'h77, 1'b0);
        chk("ovf_set", 32'(bus.overflow_o), 32'd1);
        for (int i = 0; i < ELS + 2; i++) tick(1'b0, 8'h00, 1'b1);
        chk("ovf_sticky", 32'(bus.overflow_o), 32'd1);
        chk("ovf_drained", 32'(bus.v_o), 32'd0);

        // reset mid-operation discards words and restarts the credit burst
        for (int i = 0; i < 4; i++) tick(1'b1, 8'(8'hC0 + i), 1'b0);
        reset_cycle();
        chk("mid_rst_v_o", 32'(bus.v_o), 32'd0);
        chk("mid_rst_ovf", 32'(bus.overflow_o), 32'd0);
        chk("mid_rst_credit", 32'(bus.credit_o), 32'd0);
        seen_credits = 0;
        for (int i = 0; i < ELS + 3; i++) tick(1'b0, 8'h00, 1'b1);
        chk("mid_rst_burst", 32'(seen_credits), 32'(ELS));

        // random traffic obeying upstream credits
        for (int i = 0; i < 600; i++) begin
            v = (up_cred > 0) && ($urandom_range(0, 3) != 0);
            d = 8'($urandom);
            tick(v, d, 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < ELS + 3; i++) tick(1'b0, 8'h00, 1'b1);
        chk("final_no_ovf", 32'(bus.overflow_o), 32'd0);
        chk("final_empty", 32'(bus.v_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
